gpu: RTL and testbench

- Minimal single-issue shader processor with a unified 1024x16 program/data memory.
- While prog_loading is high, memory is bulk-loaded in parallel from a flat frame bus.
- When prog_loading falls, the core executes one 16-bit instruction per clock from address 0 until HALT.
- Shader results stream out as 16-bit pixel words.

---
 rtl/gpu.sv | 174 +++++++++++++++++
 tb/tb_gpu.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu.sv
// gpu: single-issue 16-bit shader core with a unified DATA_DEPTH x 16 program/data memory.
// While prog_loading is high, the whole memory is loaded in parallel from data_frames_in.
// When prog_loading falls, one instruction executes per clock from address 0 until HALT.
// Optional feature: define GPU_MUL_EN to turn opcode F into a 16-bit unsigned MUL;
// without it, opcode F behaves as NOP and no multiplier exists.
module gpu #(
    parameter int DATA_DEPTH = 1024,
    parameter int ADDR_W     = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     prog_loading,
    input  logic [DATA_DEPTH*16-1:0] data_frames_in,
    output logic                     frame_being_sent,
    output logic [15:0]              pixel_out,
    output logic                     pixel_valid,
    output logic                     halted
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_LDI  = 4'h8,
        OP_LD   = 4'h9,
        OP_ST   = 4'hA,
        OP_BNZ  = 4'hB,
        OP_JMP  = 4'hC,
        OP_OUT  = 4'hD,
        OP_HALT = 4'hE,
        OP_EXT  = 4'hF
    } opcode_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    logic [15:0]       mem  [DATA_DEPTH];
    logic [15:0]       regs [8];
    logic [ADDR_W-1:0] pc;
    state_t            state;

    logic [15:0]       instr;
    opcode_t           op;
    logic [2:0]        rd_idx;
    logic [2:0]        rs_idx;
    logic [2:0]        rt_idx;
    logic [15:0]       rd_val;
    logic [15:0]       rs_val;
    logic [15:0]       rt_val;
    logic [15:0]       branch_off;
    logic [15:0]       wb_val;
    logic              reg_we;
    logic [ADDR_W-1:0] next_pc;
    logic              executing;

    // Combinational fetch and register-file read for the instruction at pc.
    always_comb begin
        instr      = mem[pc];
        op         = opcode_t'(instr[15:12]);
        rd_idx     = instr[11:9];
        rs_idx     = instr[8:6];
        rt_idx     = instr[5:3];
        rd_val     = regs[rd_idx];
        rs_val     = regs[rs_idx];
        rt_val     = regs[rt_idx];
        branch_off = {{8{instr[7]}}, instr[7:0]};
        executing  = reset && !prog_loading && (state == ST_RUN);
    end

    // Result selection and register write enable for the current instruction.
    always_comb begin
        wb_val = '0;
        reg_we = 1'b0;
        case (op)
            OP_ADD: begin wb_val = rs_val + rt_val;       reg_we = 1'b1; end
            OP_SUB: begin wb_val = rs_val - rt_val;       reg_we = 1'b1; end
            OP_AND: begin wb_val = rs_val & rt_val;       reg_we = 1'b1; end
            OP_OR:  begin wb_val = rs_val | rt_val;       reg_we = 1'b1; end
            OP_XOR: begin wb_val = rs_val ^ rt_val;       reg_we = 1'b1; end
            OP_SHL: begin wb_val = rs_val << rt_val[3:0]; reg_we = 1'b1; end
            OP_SHR: begin wb_val = rs_val >> rt_val[3:0]; reg_we = 1'b1; end
            OP_LDI: begin wb_val = {8'h00, instr[7:0]};   reg_we = 1'b1; end
            OP_LD:  begin wb_val = mem[rs_val[ADDR_W-1:0]]; reg_we = 1'b1; end
`ifdef GPU_MUL_EN
            OP_EXT: begin wb_val = rs_val * rt_val;       reg_we = 1'b1; end
`endif
            default: ;
        endcase
    end

    // Next program counter; all arithmetic wraps modulo the memory depth.
    always_comb begin
        next_pc = pc + ADDR_W'(1);
        case (op)
            OP_BNZ: begin
                if (rd_val != 16'h0000) begin
                    next_pc = pc + ADDR_W'(1) + branch_off[ADDR_W-1:0];
                end
            end
            OP_JMP:  next_pc = instr[ADDR_W-1:0];
            OP_HALT: next_pc = pc;
            default: ;
        endcase
    end

    // Unified memory: bulk parallel load in load mode, single-word store while executing.
    always_ff @(posedge clk) begin
        if (prog_loading) begin
            for (int unsigned j = 0; j < DATA_DEPTH; j++) begin
                mem[j] <= data_frames_in[16*j +: 16];
            end
        end else if (executing && op == OP_ST) begin
            mem[rs_val[ADDR_W-1:0]] <= rt_val;
        end
    end

    // Core control FSM: pc, registers and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= ST_RUN;
            pc               <= '0;
            pixel_out        <= '0;
            pixel_valid      <= 1'b0;
            frame_being_sent <= 1'b0;
            halted           <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (prog_loading) begin
            state            <= ST_RUN;
            pc               <= '0;
            pixel_valid      <= 1'b0;
            frame_being_sent <= 1'b0;
            halted           <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    pc               <= next_pc;
                    pixel_valid      <= 1'b0;
                    frame_being_sent <= 1'b1;
                    if (reg_we) begin
                        regs[rd_idx] <= wb_val;
                    end
                    if (op == OP_OUT) begin
                        pixel_out   <= rs_val;
                        pixel_valid <= 1'b1;
                    end
                    if (op == OP_HALT) begin
                        state            <= ST_HALT;
                        halted           <= 1'b1;
                        frame_being_sent <= 1'b0;
                    end
                end
                ST_HALT: begin
                    pixel_valid      <= 1'b0;
                    frame_being_sent <= 1'b0;
                    halted           <= 1'b1;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu.sv
// tb_gpu: self-checking bench for gpu. Directed program table, random straight-line
// programs checked against an instruction-level interpreter, and hand-written
// abort/reset sequences.
module tb_gpu;

    localparam int DEPTH = 1024;

    logic                clk = 1'b0;
    logic                reset;
    logic                prog_loading;
    logic [DEPTH*16-1:0] frames;
    logic                fbs;
    logic [15:0]         pout;
    logic                pv;
    logic                halted;

    gpu #(.DATA_DEPTH(DEPTH), .ADDR_W(10)) dut (
        .clk              (clk),
        .reset            (reset),
        .prog_loading     (prog_loading),
        .data_frames_in   (frames),
        .frame_being_sent (fbs),
        .pixel_out        (pout),
        .pixel_valid      (pv),
        .halted           (halted)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [15:0] img [DEPTH];
    logic [15:0] got_pix [$];
    logic [15:0] exp_pix [$];

    typedef struct packed {
        logic [0:9][15:0] prog;
        logic [15:0]      pre200;
        logic [15:0]      npix;
        logic [0:3][15:0] pix;
        logic [15:0]      halt_edge;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [0:9][15:0] p, input logic [15:0] pre,
                                input logic [15:0] n, input logic [0:3][15:0] px,
                                input logic [15:0] he);
        vec_t v;
        v.prog = p; v.pre200 = pre; v.npix = n; v.pix = px; v.halt_edge = he;
        return v;
    endfunction

    // Drive the image into the frame bus and hold load mode for two edges.
    task automatic load_image();
        prog_loading = 1'b1;
        for (int j = 0; j < DEPTH; j++) frames[16*j +: 16] = img[j];
        @(negedge clk);
        @(negedge clk);
    endtask

    // Execute for up to max_edges edges, collecting pixels and checking run/halt status.
    task automatic run_dut(input string name, input int max_edges, output int halt_edge);
        int bad_fbs;
        int bad_freeze;
        logic [15:0] held;
        got_pix.delete();
        halt_edge = 0;
        bad_fbs = 0;
        prog_loading = 1'b0;
        for (int e = 1; e <= max_edges; e++) begin
            @(negedge clk);
            if (pv) got_pix.push_back(pout);
            if (halted) begin
                halt_edge = e;
                break;
            end
            if (!fbs) bad_fbs++;
        end
        chk({name, "_fbs_running"}, bad_fbs, 0);
        if (halt_edge != 0) begin
            chk({name, "_fbs_halt"}, {31'b0, fbs}, 0);
            bad_freeze = 0;
            held = pout;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (pv || !halted || fbs || pout !== held) bad_freeze++;
            end
            chk({name, "_halt_freeze"}, bad_freeze, 0);
        end
    endtask

    task automatic compare_pixels(input string name);
        chk({name, "_npix"}, got_pix.size(), exp_pix.size());
        for (int k = 0; k < exp_pix.size() && k < got_pix.size(); k++)
            chk($sformatf("%s_pix%0d", name, k), {16'b0, got_pix[k]}, {16'b0, exp_pix[k]});
    endtask

    // Instruction-level interpreter over the loaded image.
    task automatic model_run(input int max_edges, output int halt_edge);
        int mm [DEPTH];
        int r [8];
        int pc;
        int w, op, rd, rs, rt, imm, simm;
        longint prod;
        exp_pix.delete();
        halt_edge = 0;
        for (int j = 0; j < DEPTH; j++) mm[j] = int'(img[j]);
        for (int j = 0; j < 8; j++) r[j] = 0;
        pc = 0;
        for (int e = 1; e <= max_edges; e++) begin
            w = mm[pc];
            op = (w >> 12) & 15; rd = (w >> 9) & 7; rs = (w >> 6) & 7; rt = (w >> 3) & 7;
            imm = w & 255;
            simm = (imm >= 128) ? imm - 256 : imm;
            pc = (pc + 1) % DEPTH;
            case (op)
                1:  r[rd] = (r[rs] + r[rt]) & 16'hFFFF;
                2:  r[rd] = (r[rs] - r[rt]) & 16'hFFFF;
                3:  r[rd] = r[rs] & r[rt];
                4:  r[rd] = r[rs] | r[rt];
                5:  r[rd] = r[rs] ^ r[rt];
                6:  r[rd] = (r[rs] << (r[rt] % 16)) & 16'hFFFF;
                7:  r[rd] = r[rs] >> (r[rt] % 16);
                8:  r[rd] = imm;
                9:  r[rd] = mm[r[rs] % DEPTH];
                10: mm[r[rs] % DEPTH] = r[rt];
                11: if (r[rd] != 0) pc = (pc + simm + DEPTH) % DEPTH;
                12: pc = w % DEPTH;
                13: exp_pix.push_back(16'(r[rs]));
                14: begin halt_edge = e; break; end
`ifdef GPU_MUL_EN
                15: begin prod = longint'(r[rs]) * longint'(r[rt]); r[rd] = int'(prod & 64'hFFFF); end
`endif
                default: ;
            endcase
        end
    endtask

    initial begin
        int he;
        int mhe;
        int op_pool [15];
        logic [15:0] mul_exp;

        reset = 1'b0;
        prog_loading = 1'b1;
        frames = '0;

        // ---- reset state ----
        @(negedge clk);
        @(negedge clk);
        chk("rst_pixel_out", {16'b0, pout}, 0);
        chk("rst_pixel_valid", {31'b0, pv}, 0);
        chk("rst_fbs", {31'b0, fbs}, 0);
        chk("rst_halted", {31'b0, halted}, 0);
        reset = 1'b1;
        @(negedge clk);
        prog_loading = 1'b0;
        @(negedge clk);
        chk("rst_fbs_after_release", {31'b0, fbs}, 1);
        chk("rst_halted_after_release", {31'b0, halted}, 0);

        // ---- directed program table ----
`ifdef GPU_MUL_EN
        mul_exp = 16'h0100;
`else
        mul_exp = 16'h0055;
`endif
        vecs[0] = mk({16'h8205, 16'h8403, 16'h1650, 16'hD0C0, 16'hE000,
                      16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                     16'h0, 16'd1, {16'h0008, 16'h0, 16'h0, 16'h0}, 16'd5);
        vecs[1] = mk({16'h8203, 16'h8401, 16'h2250, 16'hD040, 16'hB2FD,
                      16'hE000, 16'h0, 16'h0, 16'h0, 16'h0},
                     16'h0, 16'd3, {16'h0002, 16'h0001, 16'h0000, 16'h0}, 16'd12);
        vecs[2] = mk({16'h82C8, 16'h847F, 16'hA050, 16'h9640, 16'hD0C0,
                      16'hE000, 16'h0, 16'h0, 16'h0, 16'h0},
                     16'h0, 16'd1, {16'h007F, 16'h0, 16'h0, 16'h0}, 16'd6);
        vecs[3] = mk({16'h82C8, 16'h9640, 16'hD0C0, 16'h847F, 16'hA050,
                      16'h9840, 16'hD100, 16'hE000, 16'h0, 16'h0},
                     16'h1234, 16'd2, {16'h1234, 16'h007F, 16'h0, 16'h0}, 16'd8);
        vecs[4] = mk({16'hB202, 16'h8209, 16'hC3FF, 16'hD040, 16'hE000,
                      16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                     16'h0, 16'd1, {16'h0009, 16'h0, 16'h0, 16'h0}, 16'd7);
        vecs[5] = mk({16'h8201, 16'h8808, 16'h6260, 16'h8401, 16'h4488,
                      16'h8655, 16'hF650, 16'hD0C0, 16'hE000, 16'h0},
                     16'h0, 16'd1, {mul_exp, 16'h0, 16'h0, 16'h0}, 16'd9);

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < DEPTH; j++) img[j] = '0;
            for (int k = 0; k < 10; k++) img[k] = vecs[i].prog[k];
            img[200] = vecs[i].pre200;
            load_image();
            run_dut($sformatf("vec%0d", i), 60, he);
            chk($sformatf("vec%0d_halt_edge", i), he, {16'b0, vecs[i].halt_edge});
            exp_pix.delete();
            for (int k = 0; k < int'(vecs[i].npix); k++) exp_pix.push_back(vecs[i].pix[k]);
            compare_pixels($sformatf("vec%0d", i));
        end

        // ---- reset while halted clears halt ----
        reset = 1'b0;
        #1;
        chk("halted_cleared_by_reset", {31'b0, halted}, 0);
        @(negedge clk);
        reset = 1'b1;

        // ---- random straight-line programs vs. interpreter ----
        op_pool = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 8, 9, 10, 13, 13, 15};
        for (int t = 0; t < 20; t++) begin
            for (int j = 0; j < DEPTH; j++) img[j] = 16'($urandom);
            for (int k = 0; k < 24; k++)
                img[k] = {4'(op_pool[$urandom_range(14, 0)]), 12'($urandom)};
            img[24] = 16'hE000;
            model_run(100, mhe);
            load_image();
            run_dut($sformatf("rnd%0d", t), 100, he);
            chk($sformatf("rnd%0d_halt_edge", t), he, mhe);
            compare_pixels($sformatf("rnd%0d", t));
        end

        // ---- abort via prog_loading, then asynchronous reset mid-run ----
        for (int j = 0; j < DEPTH; j++) img[j] = '0;
        img[0] = 16'hD040;
        img[1] = 16'h8242;
        img[2] = 16'hC000;
        load_image();
        prog_loading = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_pre_pv", {31'b0, pv}, 1);
        chk("abort_pre_pix", {16'b0, pout}, 16'h0042);
        @(negedge clk);
        prog_loading = 1'b1;
        @(negedge clk);
        chk("abort_pv", {31'b0, pv}, 0);
        chk("abort_fbs", {31'b0, fbs}, 0);
        prog_loading = 1'b0;
        @(negedge clk);
        chk("restart_pv", {31'b0, pv}, 1);
        chk("restart_pix_regs_cleared", {16'b0, pout}, 0);
        @(negedge clk);
        chk("restart_pv_gap", {31'b0, pv}, 0);
        @(negedge clk);
        @(negedge clk);
        chk("restart_pv2", {31'b0, pv}, 1);
        chk("restart_pix2", {16'b0, pout}, 16'h0042);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_pv", {31'b0, pv}, 0);
        chk("async_rst_pix", {16'b0, pout}, 0);
        chk("async_rst_fbs", {31'b0, fbs}, 0);
        chk("async_rst_halted", {31'b0, halted}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_restart_pv", {31'b0, pv}, 1);
        chk("post_rst_restart_pix", {16'b0, pout}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
